cordic_exp: RTL
===============

Name: cordic_exp

Overview:
- Computes e^x for a signed Q16.16 input using hyperbolic CORDIC in rotation mode, with ln2 range reduction ahead of the CORDIC.
- It is the inverse of the team's pipelined natural-log CORDIC. The two blocks together form the log/exp pair used for gain and dB-domain processing.
- Fully pipelined: accepts one sample per clock and produces one result per clock.

Parameters:
- PIPELINE, 16, number of CORDIC micro-rotation stages (1..16). Stage i uses shift i; stages with i%4==0 perform a repeated rotation.
- INV_GAIN, 79137, 1/A_h in Q16.16 (1.207534), used as the initial x. It must match the repeat schedule.
- LN2, 45426, ln2 in Q16.16.
- INV_LN2, 94548, 1/ln2 in Q16.16.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- iData  input  32  signed Q16.16 exponent x
- pre_vaild  input  1  iData valid this cycle
- oExp  output  32  unsigned Q16.16 e^x, saturated
- post_vaild  output  1  oExp valid

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. On reset, oExp=0 and post_vaild=0, and all pipeline X/Y/Z registers and n registers clear to 0. The valid shift register also clears.
- Latency: exactly PIPELINE+2 cycles from pre_vaild to post_vaild. No backpressure.
- Stage R (range reduction, registered):
  - p = iData*INV_LN2 as a 64-bit signed product; n = p>>>32 (floor).
  - r = iData - n*LN2, with r in [0, LN2] and a small error tolerated.
  - n is clamped to the 6-bit signed range.
  - Registered outputs: X0=INV_GAIN, Y0=0, Z0=r, and n.
- CORDIC stages i=1..PIPELINE:
  - d = +1 if Z>=0 (sign bit 0), otherwise -1.
  - X' = X + d*(Y>>>i); Y' = Y + d*(X>>>i); Z' = Z - d*atanh_tab[i-1].
  - The atanh table is the team's standard Q16.16 table: 35999, 16739, 8235, 4101, 2049, 1024, 512, 256, 128, 64, 32, 16, 8, 4, 2, 1.
  - When i%4==0, the rotation is applied twice within the stage (chained combinationally), using a fresh sign decision on the intermediate Z.
  - n is delayed alongside each stage.
- Output stage:
  - s = X+Y (= e^r, nominally 65536..131072), computed 33-bit unsigned.
  - n>=0: v = s<<n, computed 48-bit. If v>=2^32 or n>=16, oExp=32'hFFFFFFFF.
  - n<0: oExp = s>>(-n) (logical). If n<=-17, oExp=0.
- Valid handling:
  - When the delayed valid is 0, oExp is forced to 0 and post_vaild=0.
  - Bubbles propagate unchanged; back-to-back samples are independent.
- Boundaries:
  - x=0 yields n=0, r=0.
  - Negative r from rounding (|r|<4 LSB) is legal; the CORDIC converges for |z|<1.118.
  - Reset mid-stream discards all in-flight samples; no post_vaild is produced for them.
- Accuracy: relative error <=2^-13 for x in [-11.0, 11.0) where the result is >=1.0. Absolute error <=8 LSB below 1.0.

Test Plan:
- Single sample x=0 (0x00000000) -> post_vaild exactly PIPELINE+2 cycles later, oExp=65536±8.
- x=1.0 (65536) -> oExp≈178145; x=-1.0 (-65536) -> oExp≈24109; both within tolerance.
- x=10.0 (655360) -> oExp≈1443526463 within 2^-13 relative. x=12.0 (786432) -> oExp=32'hFFFFFFFF.
- x=-12.0 (-786432) -> oExp=0 with post_vaild=1. x=-5.0 -> oExp≈441 (e^-5*65536=441.6) ±8 LSB.
- Continuous stream of 1000 random x in [-11,11] with random pre_vaild gaps -> ordering preserved, post_vaild pattern equals pre_vaild delayed PIPELINE+2, every result within tolerance of a real-valued model, oExp=0 during gaps.
- Assert rst_n for 1 cycle while 5 samples are in flight -> post_vaild and oExp read 0 immediately and stay 0 until new input. The first post-reset sample returns after PIPELINE+2 cycles with the correct value.

Source files
------------

// File: rtl/cordic_exp.sv
// cordic_exp: pipelined e^x for a signed Q16.16 exponent.
// A registered ln2 range-reduction stage splits x into n*ln2 + r, then
// PIPELINE hyperbolic CORDIC stages (rotation mode) turn r into
// cosh(r)+sinh(r) = e^r, and a final registered stage applies 2^n with
// saturation. One sample in and one result out per clock, latency
// PIPELINE+2, no backpressure.
//
// Handshake: pre_vaild qualifies iData in the cycle it is high; post_vaild
// is pre_vaild delayed by PIPELINE+2 clocks and qualifies oExp. There is no
// ready, so every accepted sample emerges. oExp is 0 whenever post_vaild is 0.
//
// Datapath formats: Z (residual angle) is Q16.16 to match the atanh table.
// X and Y carry GB extra fraction bits (Q3.29) so that shift truncation in
// the micro-rotations stays well below the output LSB; the sum is rounded
// back to Q16.16 in the output stage.
module cordic_exp #(
    parameter int PIPELINE = 16,
    parameter int INV_GAIN = 79137,
    parameter int LN2      = 45426,
    parameter int INV_LN2  = 94548
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] iData,
    input  logic        pre_vaild,
    output logic [31:0] oExp,
    output logic        post_vaild
);

    localparam int GB = 13;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
    } xyz_t;

    // atanh(2^-(idx+1)) in Q16.16
    function automatic logic [31:0] atanh_lut(input int idx);
        case (idx)
            0:       return 32'd35999;
            1:       return 32'd16739;
            2:       return 32'd8235;
            3:       return 32'd4101;
            4:       return 32'd2049;
            5:       return 32'd1024;
            6:       return 32'd512;
            7:       return 32'd256;
            8:       return 32'd128;
            9:       return 32'd64;
            10:      return 32'd32;
            11:      return 32'd16;
            12:      return 32'd8;
            13:      return 32'd4;
            14:      return 32'd2;
            default: return 32'd1;
        endcase
    endfunction

    // One hyperbolic micro-rotation with shift sh; direction from sign of z.
    function automatic xyz_t micro_rot(input xyz_t a, input int sh);
        xyz_t        o;
        logic [31:0] xs;
        logic [31:0] ys;
        logic [31:0] ang;
        xs  = $signed(a.x) >>> sh;
        ys  = $signed(a.y) >>> sh;
        ang = atanh_lut(sh - 1);
        if (a.z[31] == 1'b0) begin
            o.x = a.x + ys;
            o.y = a.y + xs;
            o.z = a.z - ang;
        end else begin
            o.x = a.x - ys;
            o.y = a.y - xs;
            o.z = a.z + ang;
        end
        return o;
    endfunction

    // Pipeline registers: index 0 is the range-reduction stage, 1..PIPELINE
    // are the CORDIC stages.
    logic [31:0] x_q [0:PIPELINE];
    logic [31:0] y_q [0:PIPELINE];
    logic [31:0] z_q [0:PIPELINE];
    logic [5:0]  n_q [0:PIPELINE];
    logic        v_q [0:PIPELINE];
    logic [31:0] x_d [0:PIPELINE];
    logic [31:0] y_d [0:PIPELINE];
    logic [31:0] z_d [0:PIPELINE];
    logic [5:0]  n_d [0:PIPELINE];
    logic        v_d [0:PIPELINE];

    logic signed [63:0] prod_w;
    logic signed [63:0] n_full_w;
    logic [31:0]        n_lo_w;
    logic [31:0]        r_w;
    logic [5:0]         n_clamp_w;

    // Range reduction: n = floor(x/ln2), r = x - n*ln2, n clamped to 6 bits.
    // r is formed with the unclamped n; whenever the clamp engages the output
    // stage saturates, so r is irrelevant there.
    always_comb begin
        prod_w   = 64'($signed(iData)) * 64'(INV_LN2);
        n_full_w = prod_w >>> 32;
        n_lo_w   = n_full_w[31:0];
        r_w      = iData - n_lo_w * 32'(LN2);
        if (n_full_w > 64'sd31) begin
            n_clamp_w = 6'd31;
        end else if (n_full_w < -64'sd32) begin
            n_clamp_w = 6'b100000;
        end else begin
            n_clamp_w = n_full_w[5:0];
        end
    end

    xyz_t st;

    // Next state of every pipeline stage: seed stage, then micro-rotations
    // (stages whose index is a multiple of 4 rotate twice for convergence).
    always_comb begin
        st     = '0;
        x_d[0] = 32'(INV_GAIN) << GB;
        y_d[0] = '0;
        z_d[0] = r_w;
        n_d[0] = n_clamp_w;
        v_d[0] = pre_vaild;
        for (int i = 1; i <= PIPELINE; i++) begin
            st = micro_rot({x_q[i-1], y_q[i-1], z_q[i-1]}, i);
            if (i % 4 == 0) begin
                st = micro_rot(st, i);
            end
            x_d[i] = st.x;
            y_d[i] = st.y;
            z_d[i] = st.z;
            n_d[i] = n_q[i-1];
            v_d[i] = v_q[i-1];
        end
    end

    // Pipeline state registers, all cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= PIPELINE; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
                z_q[i] <= '0;
                n_q[i] <= '0;
                v_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i <= PIPELINE; i++) begin
                x_q[i] <= x_d[i];
                y_q[i] <= y_d[i];
                z_q[i] <= z_d[i];
                n_q[i] <= n_d[i];
                v_q[i] <= v_d[i];
            end
        end
    end

    logic [33:0] sum_w;
    logic [32:0] s_w;
    logic [47:0] v_w;
    logic [5:0]  nn_w;
    logic [31:0] oexp_d;
    logic [31:0] oexp_q;
    logic        vout_q;

    // Output stage: e^r = X+Y rounded to Q16.16, scaled by 2^n with
    // saturation at both ends; bubbles produce 0.
    always_comb begin
        sum_w = {{2{x_q[PIPELINE][31]}}, x_q[PIPELINE]}
              + {{2{y_q[PIPELINE][31]}}, y_q[PIPELINE]}
              + 34'(1 << (GB - 1));
        s_w    = sum_w[33] ? '0 : 33'(sum_w >> GB);
        v_w    = '0;
        nn_w   = '0;
        oexp_d = '0;
        if (!v_q[PIPELINE]) begin
            oexp_d = '0;
        end else if (!n_q[PIPELINE][5]) begin
            v_w = {15'b0, s_w} << n_q[PIPELINE][3:0];
            if (n_q[PIPELINE][4] || (v_w[47:32] != 16'd0)) begin
                oexp_d = '1;
            end else begin
                oexp_d = v_w[31:0];
            end
        end else begin
            nn_w = -n_q[PIPELINE];
            if (nn_w >= 6'd17) begin
                oexp_d = '0;
            end else begin
                oexp_d = 32'(s_w >> nn_w);
            end
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oexp_q <= '0;
            vout_q <= 1'b0;
        end else begin
            oexp_q <= oexp_d;
            vout_q <= v_q[PIPELINE];
        end
    end

    assign oExp       = oexp_q;
    assign post_vaild = vout_q;

endmodule
